// File: rtl/nibble_serial_adder.sv
// Add/subtract engine that processes one 4-bit nibble per clock through a ripple-carry cell.
// Request/response handshakes on both sides; sum, carry and signed overflow are held until consumed.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic             carry_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             carry_out_p1;
  logic             overflow_p1;
  logic             accept;
  logic             last_nib;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c3;
  logic             nib_c4;

  // Returns {carry_out, carry_into_bit3, sum[3:0]}; the bit-3 carry feeds signed overflow.
  function automatic logic [5:0] nibble_add(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci);
    logic [3:0] s;
    logic       c;
    logic       c3;
    s  = 4'd0;
    c  = ci;
    c3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) c3 = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, c3, s};
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_nib = (cnt == CNT_W'(NIBBLES - 1));
  assign nib_a    = op_a_p0[{cnt, 2'b00} +: 4];
  assign nib_b    = op_b_p0[{cnt, 2'b00} +: 4];
  assign {nib_c4, nib_c3, nib_s} = nibble_add(nib_a, nib_b, carry_p0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_nib) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture; subtraction folds into inverted b plus carry-in of 1
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_p0 <= a;
      op_b_p0 <= b ^ {WIDTH{sub}};
    end
  end

  // Stage p1: one nibble per BUSY cycle; flags latch only on the final nibble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      carry_p0     <= 1'b0;
      sum_p1       <= '0;
      carry_out_p1 <= 1'b0;
      overflow_p1  <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      carry_p0 <= sub;
    end else if (state == BUSY) begin
      sum_p1[{cnt, 2'b00} +: 4] <= nib_s;
      carry_p0                  <= nib_c4;
      if (last_nib) begin
        cnt          <= '0;
        carry_out_p1 <= nib_c4;
        overflow_p1  <= nib_c3 ^ nib_c4;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sum       = sum_p1;
  assign carry_out = carry_out_p1;
  assign overflow  = overflow_p1;
  assign zero      = (sum_p1 == '0);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=32): latency, flags, hold behaviour and async reset.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int n_checks;
  int n_pass;

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and count rising edges until out_valid; -1 if it never arrives.
  task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic sub_i,
                        output int lat);
    @(negedge clk);
    a = a_i; b = b_i; sub = sub_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({in_ready, out_valid, sum, carry_out, overflow, zero} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h c=%b v=%b z=%b, want rdy=1 vld=0 sum=0 c=0 v=0 z=1",
               in_ready, out_valid, sum, carry_out, overflow, zero);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL after_reset_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_add_basic();
    int lat;
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
    n_checks++;
    if (lat !== 8) $display("FAIL add_latency: got %0d edges, want 8", lat);
    else n_pass++;
    n_checks++;
    if ({sum, carry_out, overflow, zero} !== {32'h0000_0008, 1'b0, 1'b0, 1'b0})
      $display("FAIL add_5_3: got sum=%h c=%b v=%b z=%b, want sum=00000008 c=0 v=0 z=0",
               sum, carry_out, overflow, zero);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL done_not_ready: got in_ready=%b, want 0", in_ready);
    else n_pass++;
    release_result();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL add_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_carry_ripple();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    n_checks++;
    if (lat !== 8) $display("FAIL ripple_latency: got %0d edges, want 8", lat);
    else n_pass++;
    n_checks++;
    if ({sum, carry_out, overflow, zero} !== {32'h0000_0000, 1'b1, 1'b0, 1'b1})
      $display("FAIL add_ffffffff_1: got sum=%h c=%b v=%b z=%b, want sum=00000000 c=1 v=0 z=1",
               sum, carry_out, overflow, zero);
    else n_pass++;
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || {sum, carry_out, overflow, zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_pos_ovf: got lat=%0d sum=%h c=%b v=%b z=%b, want lat=8 sum=80000000 c=0 v=1 z=0",
               lat, sum, carry_out, overflow, zero);
    else n_pass++;
    release_result();
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || {sum, carry_out, overflow, zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_neg_ovf: got lat=%0d sum=%h c=%b v=%b z=%b, want lat=8 sum=7fffffff c=1 v=1 z=0",
               lat, sum, carry_out, overflow, zero);
    else n_pass++;
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || {sum, carry_out, overflow, zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0})
      $display("FAIL sub_5_7: got lat=%0d sum=%h c=%b v=%b z=%b, want lat=8 sum=fffffffe c=0 v=0 z=0",
               lat, sum, carry_out, overflow, zero);
    else n_pass++;
    release_result();
    run_op(32'h0000_1234, 32'h0000_1234, 1'b1, lat);
    n_checks++;
    if (lat !== 8 || {sum, carry_out, overflow, zero} !== {32'h0000_0000, 1'b1, 1'b0, 1'b1})
      $display("FAIL sub_equal: got lat=%0d sum=%h c=%b v=%b z=%b, want lat=8 sum=00000000 c=1 v=0 z=1",
               lat, sum, carry_out, overflow, zero);
    else n_pass++;
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || sum !== 32'h2345_6789)
      $display("FAIL hold_setup: got lat=%0d sum=%h, want lat=8 sum=23456789", lat, sum);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'hDEAD_BEEF + i; b = 32'h0BAD_F00D; sub = i[0];
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, sum, carry_out, overflow, zero} !==
          {1'b1, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0})
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b sum=%h c=%b v=%b z=%b, want vld=1 rdy=0 sum=23456789 c=0 v=0 z=0",
                 i, out_valid, in_ready, sum, carry_out, overflow, zero);
      else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL hold_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL hold_no_queue: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midbusy_state: got rdy=%b vld=%b, want rdy=0 vld=0", in_ready, out_valid);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, sum, zero} !== {1'b0, 1'b1, 32'h0, 1'b1})
      $display("FAIL async_reset: got vld=%b rdy=%b sum=%h z=%b, want vld=0 rdy=1 sum=00000000 z=1",
               out_valid, in_ready, sum, zero);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || {sum, carry_out, overflow, zero} !== {32'h0000_0002, 1'b0, 1'b0, 1'b0})
      $display("FAIL post_reset_add: got lat=%0d sum=%h c=%b v=%b z=%b, want lat=8 sum=00000002 c=0 v=0 z=0",
               lat, sum, carry_out, overflow, zero);
    else n_pass++;
    release_result();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    test_reset();
    test_add_basic();
    test_carry_ripple();
    test_overflow();
    test_sub();
    test_hold();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
